// File: rtl/ifu_lockstep_pkg.sv
// Shared definitions for the IFU lockstep checker: bundle field layout,
// mismatch-mask bit indices and checker FSM encodings.
package ifu_lockstep_pkg;

  localparam int VALID_B   = 0;
  localparam int IR_LSB    = 1;
  localparam int IR_W      = 32;
  localparam int PC_LSB    = 33;
  localparam int PC_W      = 32;
  localparam int PC_VLD_B  = 65;
  localparam int MISALGN_B = 66;
  localparam int BUSERR_B  = 67;
  localparam int RS1_LSB   = 68;
  localparam int RS2_LSB   = 73;
  localparam int RIDX_W    = 5;
  localparam int PRDT_B    = 78;
  localparam int MULDIV_B  = 79;
  localparam int CMDV_B    = 80;
  localparam int CMDA_LSB  = 81;

  localparam int M_VALID = 0;
  localparam int M_IR    = 1;
  localparam int M_PC    = 2;
  localparam int M_EXC   = 3;
  localparam int M_RIDX  = 4;
  localparam int M_CTRL  = 5;
  localparam int M_CMD   = 6;
  localparam int M_ACK   = 7;

  typedef enum logic [1:0] {
    ST_WARM  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAULT = 2'd2
  } chk_state_e;

  // The ack bits sit above the variable-width ITCM address field.
  function automatic int flush_ack_b(input int itcm_aw);
    return CMDA_LSB + itcm_aw;
  endfunction

endpackage

// File: rtl/lockstep_dly_line.sv
// Fixed-depth register chain with synchronous clear, used to skew one copy
// of a redundant stage so it lines up with its shadow.
module lockstep_dly_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift every cycle; there is deliberately no enable so the skew is fixed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ifu_lockstep_chk.sv
// Compares the delayed main-core IFU bundle against the shadow-core bundle,
// pulses on every divergence and latches the first one as a sticky fault.
module ifu_lockstep_chk
  import ifu_lockstep_pkg::*;
#(
  parameter  int DELAY   = 2,
  parameter  int ITCM_AW = 16,
  parameter  int CNT_W   = 8,
  localparam int BUS_W   = 83 + ITCM_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             err_clr,
  input  logic [BUS_W-1:0] m_ifu_bus,
  input  logic [BUS_W-1:0] s_ifu_bus,
  output logic             lockstep_err,
  output logic             lockstep_fault,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [7:0]       err_mask,
  output logic [31:0]      err_pc,
  output logic [1:0]       chk_state
);

  localparam int FLUSH_B = flush_ack_b(ITCM_AW);
  localparam int HALT_B  = FLUSH_B + 1;

  logic [BUS_W-1:0] d_bus;
  logic [7:0]       mask_d;
  logic             both_v_s;
  logic             both_cmd_s;
  logic             mismatch_s;

  chk_state_e       state_q;
  logic [1:0]       warm_q;
  logic             err_q;
  logic             fault_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       mask_q;
  logic [31:0]      pc_q;

  lockstep_dly_line #(
    .WIDTH (BUS_W),
    .DEPTH (DELAY)
  ) u_dly (
    .clk_i  (clk),
    .rst_i  (rst),
    .din_i  (m_ifu_bus),
    .dout_o (d_bus)
  );

  // Field compare; payload fields only matter when both sides claim valid data.
  always_comb begin
    mask_d     = 8'h00;
    both_v_s   = d_bus[VALID_B] & s_ifu_bus[VALID_B];
    both_cmd_s = d_bus[CMDV_B] & s_ifu_bus[CMDV_B];
    mask_d[M_VALID] = d_bus[VALID_B] ^ s_ifu_bus[VALID_B];
    mask_d[M_IR]    = both_v_s & (d_bus[IR_LSB +: IR_W] != s_ifu_bus[IR_LSB +: IR_W]);
    mask_d[M_PC]    = both_v_s & ((d_bus[PC_LSB +: PC_W] != s_ifu_bus[PC_LSB +: PC_W]) |
                                  (d_bus[PC_VLD_B] ^ s_ifu_bus[PC_VLD_B]));
    mask_d[M_EXC]   = both_v_s & ((d_bus[MISALGN_B] ^ s_ifu_bus[MISALGN_B]) |
                                  (d_bus[BUSERR_B] ^ s_ifu_bus[BUSERR_B]));
    mask_d[M_RIDX]  = both_v_s & ((d_bus[RS1_LSB +: RIDX_W] != s_ifu_bus[RS1_LSB +: RIDX_W]) |
                                  (d_bus[RS2_LSB +: RIDX_W] != s_ifu_bus[RS2_LSB +: RIDX_W]));
    mask_d[M_CTRL]  = both_v_s & ((d_bus[PRDT_B] ^ s_ifu_bus[PRDT_B]) |
                                  (d_bus[MULDIV_B] ^ s_ifu_bus[MULDIV_B]));
    mask_d[M_CMD]   = (d_bus[CMDV_B] ^ s_ifu_bus[CMDV_B]) |
                      (both_cmd_s & (d_bus[CMDA_LSB +: ITCM_AW] != s_ifu_bus[CMDA_LSB +: ITCM_AW]));
    mask_d[M_ACK]   = (d_bus[FLUSH_B] ^ s_ifu_bus[FLUSH_B]) |
                      (d_bus[HALT_B] ^ s_ifu_bus[HALT_B]);
  end

  assign mismatch_s = (mask_d != 8'h00) && chk_en && (state_q != ST_WARM);

  // Checker FSM with counter, sticky fault and first-divergence capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WARM;
      warm_q  <= 2'd0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      mask_q  <= 8'h00;
      pc_q    <= 32'h0;
    end else begin
      err_q <= mismatch_s;
      if (mismatch_s) begin
        // A coincident clear restarts the record from this mismatch.
        fault_q <= 1'b1;
        state_q <= ST_FAULT;
        if (err_clr) begin
          cnt_q <= CNT_W'(1);
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        if (err_clr || (state_q == ST_CHECK)) begin
          mask_q <= mask_d;
          pc_q   <= d_bus[PC_LSB +: PC_W];
        end
      end else begin
        if (err_clr) begin
          fault_q <= 1'b0;
          cnt_q   <= {CNT_W{1'b0}};
          mask_q  <= 8'h00;
          pc_q    <= 32'h0;
        end
        case (state_q)
          ST_WARM: begin
            if (!chk_en) begin
              warm_q <= 2'd0;
            end else if (warm_q == 2'(DELAY - 1)) begin
              warm_q  <= 2'd0;
              state_q <= ST_CHECK;
            end else begin
              warm_q <= warm_q + 2'd1;
            end
          end
          ST_CHECK: begin
            if (!chk_en) state_q <= ST_WARM;
          end
          ST_FAULT: begin
            if (!chk_en)      state_q <= ST_WARM;
            else if (err_clr) state_q <= ST_CHECK;
          end
          default: state_q <= ST_WARM;
        endcase
      end
    end
  end

  assign lockstep_err   = err_q;
  assign lockstep_fault = fault_q;
  assign mismatch_cnt   = cnt_q;
  assign err_mask       = mask_q;
  assign err_pc         = pc_q;
  assign chk_state      = state_q;

endmodule

// File: tb/tb_ifu_lockstep_chk.sv
// Scoreboard bench for ifu_lockstep_chk: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_ifu_lockstep_chk;

  localparam int DELAY = 2;
  localparam int AW    = 16;
  localparam int CW    = 8;
  localparam int BW    = 83 + AW;

  typedef logic [BW-1:0] bus_t;

  typedef struct {
    int          cyc;
    string       name;
    logic        err;
    logic        fault;
    logic [7:0]  cnt;
    logic [7:0]  mask;
    logic [31:0] pc;
    logic [1:0]  st;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          chk_en;
  logic          err_clr;
  bus_t          m_ifu_bus;
  bus_t          s_ifu_bus;
  logic          lockstep_err;
  logic          lockstep_fault;
  logic [CW-1:0] mismatch_cnt;
  logic [7:0]    err_mask;
  logic [31:0]   err_pc;
  logic [1:0]    chk_state;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 1'b0;
  bit   done   = 1'b0;
  exp_t q[$];
  bus_t mp1, mp2;

  ifu_lockstep_chk #(
    .DELAY   (DELAY),
    .ITCM_AW (AW),
    .CNT_W   (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .chk_en         (chk_en),
    .err_clr        (err_clr),
    .m_ifu_bus      (m_ifu_bus),
    .s_ifu_bus      (s_ifu_bus),
    .lockstep_err   (lockstep_err),
    .lockstep_fault (lockstep_fault),
    .mismatch_cnt   (mismatch_cnt),
    .err_mask       (err_mask),
    .err_pc         (err_pc),
    .chk_state      (chk_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bus_t mk(input logic v, input logic [31:0] ir, input logic [31:0] pc);
    bus_t b;
    b = {BW{1'b0}};
    b[0]     = v;
    b[32:1]  = ir;
    b[64:33] = pc;
    b[65]    = v;
    return b;
  endfunction

  // Drive one cycle; the shadow copy is the main bundle from DELAY cycles ago, xor x.
  task automatic drv(input bus_t m, input bus_t x, input logic r, input logic en, input logic clr);
    @(posedge clk);
    #1;
    rst       = r;
    chk_en    = en;
    err_clr   = clr;
    m_ifu_bus = m;
    s_ifu_bus = mp2 ^ x;
    mp2       = mp1;
    mp1       = m;
  endtask

  task automatic ex(input int c, input string n, input logic e, input logic f,
                    input logic [7:0] cnt, input logic [7:0] mask, input logic [31:0] pc,
                    input logic [1:0] st);
    exp_t t;
    t.cyc = c; t.name = n; t.err = e; t.fault = f;
    t.cnt = cnt; t.mask = mask; t.pc = pc; t.st = st;
    q.push_back(t);
  endtask

  exp_t e;
  bit   hit;

  // Monitor: compare queued expectations; otherwise lockstep_err must be quiet.
  always @(negedge clk) begin
    hit = 1'b0;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      hit = 1'b1;
      total++;
      if (e.cyc != cyc || lockstep_err !== e.err || lockstep_fault !== e.fault ||
          mismatch_cnt !== e.cnt || err_mask !== e.mask || err_pc !== e.pc ||
          chk_state !== e.st) begin
        bad++;
        $display("FAIL %s cyc=%0d/%0d got err=%b flt=%b cnt=%0d mask=%h pc=%h st=%0d want err=%b flt=%b cnt=%0d mask=%h pc=%h st=%0d",
                 e.name, cyc, e.cyc, lockstep_err, lockstep_fault, mismatch_cnt, err_mask,
                 err_pc, chk_state, e.err, e.fault, e.cnt, e.mask, e.pc, e.st);
      end
    end
    if (!hit && mon_on) begin
      total++;
      if (lockstep_err !== 1'b0) begin
        bad++;
        $display("FAIL spurious_err cyc=%0d got=%b want=0", cyc, lockstep_err);
      end
    end
    if (done && q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL pending_expectations got=%0d want=0", q.size());
      q.delete();
    end
  end

  initial begin
    bus_t junk, irx, rsx, flx, hlx, vx, dx, ax, ma, qb, hb, idle_b, xk;
    int   c0, p0, q0, r0, e0;

    junk   = {BW{1'b1}};
    irx    = bus_t'(32'h0010_0000) << 1;
    rsx    = bus_t'(1) << 68;
    flx    = bus_t'(1) << (81 + AW);
    hlx    = bus_t'(1) << (82 + AW);
    vx     = bus_t'(1);
    dx     = (bus_t'(32'h1234 ^ 32'h5678) << 1) | (bus_t'(32'h10 ^ 32'h20) << 33);
    ax     = bus_t'(16'h1234 ^ 16'hABCD) << 81;
    ma     = mk(1'b1, 32'h13, 32'h400) | (bus_t'(16'h1234) << 81);
    qb     = mk(1'b1, 32'h33, 32'h8000_0300);
    hb     = mk(1'b1, 32'h77, 32'h8000_0400);
    idle_b = mk(1'b1, 32'h0, 32'h0);

    rst = 1'b1; chk_en = 1'b0; err_clr = 1'b0;
    m_ifu_bus = {BW{1'b0}}; s_ifu_bus = {BW{1'b0}};
    mp1 = {BW{1'b0}}; mp2 = {BW{1'b0}};

    // Reset state
    drv({BW{1'b0}}, {BW{1'b0}}, 1'b1, 1'b0, 1'b0);
    drv({BW{1'b0}}, {BW{1'b0}}, 1'b1, 1'b0, 1'b0);
    ex(cyc + 1, "reset", 1'b0, 1'b0, 8'd0, 8'h00, 32'h0, 2'd0);
    mon_on = 1'b1;

    // Warm-up gating: shadow junk in the first DELAY cycles is ignored
    for (int k = 0; k < 102; k++) begin
      drv(mk(1'b1, k, 32'h1000 + 32'(4 * k)), (k < 2) ? junk : {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
      if (k == 0) begin
        for (int j = 0; j < 102; j++) begin
          ex(cyc + j, "warmup", 1'b0, 1'b0, 8'd0, 8'h00, 32'h0, (j < 2) ? 2'd0 : 2'd1);
        end
      end
    end

    // Single ir mismatch, then clear back to CHECK
    drv(mk(1'b1, 32'h13, 32'h8000_0100), {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    c0 = cyc;
    drv(mk(1'b1, 32'h17, 32'h8000_0104), {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    drv(mk(1'b1, 32'h1b, 32'h8000_0108), irx, 1'b0, 1'b1, 1'b0);
    ex(c0 + 3, "ir_mismatch", 1'b1, 1'b1, 8'd1, 8'h02, 32'h8000_0100, 2'd2);
    ex(c0 + 4, "ir_hold",     1'b0, 1'b1, 8'd1, 8'h02, 32'h8000_0100, 2'd2);
    ex(c0 + 6, "clr_idle",    1'b0, 1'b0, 8'd0, 8'h00, 32'h0, 2'd1);
    drv(idle_b, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    drv(idle_b, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    drv(idle_b, {BW{1'b0}}, 1'b0, 1'b1, 1'b1);
    drv(idle_b, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);

    // Don't-care payload when valid=0 on both sides
    drv(mk(1'b0, 32'h1234, 32'h10), {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    c0 = cyc;
    drv(idle_b, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    drv(idle_b, dx, 1'b0, 1'b1, 1'b0);
    ex(c0 + 4, "dontcare_valid", 1'b0, 1'b0, 8'd0, 8'h00, 32'h0, 2'd1);
    drv(idle_b, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    drv(idle_b, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);

    // Don't-care ITCM address when cmd_valid=0 on both sides
    drv(ma, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    c0 = cyc;
    drv(idle_b, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    drv(idle_b, ax, 1'b0, 1'b1, 1'b0);
    ex(c0 + 3, "dontcare_addr", 1'b0, 1'b0, 8'd0, 8'h00, 32'h0, 2'd1);
    drv(idle_b, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    drv(idle_b, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);

    // 300 mismatch cycles: count saturates, capture keeps the first one
    for (int k = 0; k < 303; k++) begin
      if (k < 2)        xk = {BW{1'b0}};
      else if (k == 2)  xk = rsx;
      else if (k < 302) xk = rsx | flx;
      else              xk = {BW{1'b0}};
      drv(mk(1'b1, 32'h0, 32'h8000_0200 + 32'(4 * k)), xk, 1'b0, 1'b1, 1'b0);
      if (k == 0) begin
        p0 = cyc;
        for (int j = 0; j < 300; j++) begin
          ex(p0 + 3 + j, "sat", 1'b1, 1'b1, (j + 1 > 255) ? 8'd255 : 8'(j + 1),
             8'h10, 32'h8000_0200, 2'd2);
        end
        ex(p0 + 303, "sat_hold", 1'b0, 1'b1, 8'd255, 8'h10, 32'h8000_0200, 2'd2);
      end
    end

    // err_clr colliding with a fresh ack mismatch, then a plain clear
    drv(qb, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    drv(qb, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    drv(qb, flx, 1'b0, 1'b1, 1'b1);
    q0 = cyc;
    ex(q0 + 1, "clr_collide", 1'b1, 1'b1, 8'd1, 8'h80, 32'h8000_0300, 2'd2);
    drv(qb, {BW{1'b0}}, 1'b0, 1'b1, 1'b1);
    ex(q0 + 2, "clr_after", 1'b0, 1'b0, 8'd0, 8'h00, 32'h0, 2'd1);

    // Reset while in FAULT, then re-warm
    drv(qb, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    drv(qb, vx, 1'b0, 1'b1, 1'b0);
    r0 = cyc;
    ex(r0 + 1, "pre_rst", 1'b1, 1'b1, 8'd1, 8'h01, 32'h8000_0300, 2'd2);
    drv(qb, {BW{1'b0}}, 1'b1, 1'b1, 1'b0);
    ex(r0 + 2, "rst_mid", 1'b0, 1'b0, 8'd0, 8'h00, 32'h0, 2'd0);
    drv(qb, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    ex(r0 + 3, "rewarm1", 1'b0, 1'b0, 8'd0, 8'h00, 32'h0, 2'd0);
    drv(qb, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    ex(r0 + 4, "rewarm2", 1'b0, 1'b0, 8'd0, 8'h00, 32'h0, 2'd1);
    drv(qb, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);

    // chk_en dropped in CHECK; divergence during re-warm is ignored
    drv(qb, {BW{1'b0}}, 1'b0, 1'b0, 1'b0);
    e0 = cyc;
    ex(e0 + 1, "en_drop", 1'b0, 1'b0, 8'd0, 8'h00, 32'h0, 2'd0);
    drv(qb, {BW{1'b0}}, 1'b0, 1'b0, 1'b0);
    drv(hb, vx, 1'b0, 1'b1, 1'b0);
    ex(e0 + 3, "rewarm_a", 1'b0, 1'b0, 8'd0, 8'h00, 32'h0, 2'd0);
    drv(qb, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    ex(e0 + 4, "rewarm_b", 1'b0, 1'b0, 8'd0, 8'h00, 32'h0, 2'd1);
    drv(qb, hlx, 1'b0, 1'b1, 1'b0);
    ex(e0 + 5, "en_mismatch", 1'b1, 1'b1, 8'd1, 8'h80, 32'h8000_0400, 2'd2);
    drv(qb, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);
    drv(qb, {BW{1'b0}}, 1'b0, 1'b1, 1'b0);

    done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
